// File: rtl/riscv_bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// BTB entry layout, counter reset value and index/tag bit ranges for the default geometry.
package riscv_bp_pkg;

    localparam int BP_XLEN        = 64;
    localparam int BP_BHT_ENTRIES = 64;
    localparam int BP_BTB_ENTRIES = 16;
    localparam int BP_TAG_BITS    = 20;

    // pc[1:0] never participates in indexing.
    localparam int BP_IDX_LSB      = 2;
    localparam int BP_BHT_IDX_BITS = $clog2(BP_BHT_ENTRIES);
    localparam int BP_BHT_IDX_MSB  = BP_BHT_IDX_BITS + 1;
    localparam int BP_BTB_IDX_BITS = $clog2(BP_BTB_ENTRIES);
    localparam int BP_BTB_IDX_MSB  = BP_BTB_IDX_BITS + 1;
    localparam int BP_TAG_LSB      = BP_BTB_IDX_MSB + 1;
    localparam int BP_TAG_MSB      = BP_TAG_LSB + BP_TAG_BITS - 1;

    localparam logic [1:0]  BP_CTR_RESET = 2'b01;
    localparam logic [1:0]  BP_CTR_MAX   = 2'b11;
    localparam logic [1:0]  BP_CTR_MIN   = 2'b00;
    localparam logic [31:0] BP_EVT_MAX   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_XLEN-1:0]     target;
        logic                   is_jump;
    } btb_entry_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] cnt,
                                                input logic       inc,
                                                input logic       dec);
        logic [1:0] nxt;
        nxt = cnt;
        if (inc && !dec && cnt != BP_CTR_MAX) begin
            nxt = cnt + 2'd1;
        end else if (dec && !inc && cnt != BP_CTR_MIN) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/riscv_bp_sat_counter.sv
// One BHT cell: 2-bit saturating counter, reset to weakly not-taken.
module riscv_bp_sat_counter
    import riscv_bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = sat_ctr_next(cnt_q, inc_i, dec_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= BP_CTR_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_branch_predictor.sv
// Fetch-stage predictor: BHT of 2-bit counters plus direct-mapped BTB, trained from execute,
// with a registered mispredict/redirect pulse and saturating event counters.
module riscv_branch_predictor
    import riscv_bp_pkg::*;
#(
    parameter int XLEN        = BP_XLEN,
    parameter int BHT_ENTRIES = BP_BHT_ENTRIES,
    parameter int BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int TAG_BITS    = BP_TAG_BITS
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_req_valid,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            flush,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int BHT_IW  = $clog2(BHT_ENTRIES);
    localparam int BTB_IW  = $clog2(BTB_ENTRIES);
    localparam int TAG_LSB = BTB_IW + 2;

    logic [BHT_IW-1:0]   p_bht_idx;
    logic [BHT_IW-1:0]   u_bht_idx;
    logic [BTB_IW-1:0]   p_btb_idx;
    logic [BTB_IW-1:0]   u_btb_idx;
    logic [TAG_BITS-1:0] p_tag;
    logic [TAG_BITS-1:0] u_tag;

    assign p_bht_idx = pred_pc[BHT_IW+1:2];
    assign u_bht_idx = upd_pc[BHT_IW+1:2];
    assign p_btb_idx = pred_pc[BTB_IW+1:2];
    assign u_btb_idx = upd_pc[BTB_IW+1:2];
    assign p_tag     = pred_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign u_tag     = upd_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];

    // BHT: jumps and non-branch updates never touch the counters.
    logic       bht_train;
    logic [1:0] bht_cnt [BHT_ENTRIES];

    assign bht_train = upd_valid && upd_is_branch;

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        logic sel;
        assign sel = bht_train && (u_bht_idx == BHT_IW'(g));
        riscv_bp_sat_counter u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (sel && upd_taken),
            .dec_i (sel && !upd_taken),
            .cnt_o (bht_cnt[g])
        );
    end

    // BTB: only the valid bits are reset; tag/target/is_jump are qualified by valid.
    logic                btb_wr;
    logic                btb_vld_q [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_tgt_q [BTB_ENTRIES];
    logic                btb_jmp_q [BTB_ENTRIES];

    assign btb_wr = upd_valid && upd_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_vld_q[i] <= 1'b0;
            end
        end else if (btb_wr) begin
            btb_vld_q[u_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag_q[u_btb_idx] <= u_tag;
            btb_tgt_q[u_btb_idx] <= upd_target;
            btb_jmp_q[u_btb_idx] <= upd_is_jump;
        end
    end

    // Lookup reads the pre-edge table contents, so a same-cycle update is not visible.
    btb_entry_t      rd_entry;
    logic            p_hit;
    logic            p_taken;
    logic [XLEN-1:0] p_target;

    always_comb begin
        rd_entry.valid   = btb_vld_q[p_btb_idx];
        rd_entry.tag     = btb_tag_q[p_btb_idx];
        rd_entry.target  = btb_tgt_q[p_btb_idx];
        rd_entry.is_jump = btb_jmp_q[p_btb_idx];
        p_hit    = rd_entry.valid && (rd_entry.tag == p_tag);
        p_taken  = p_hit && (rd_entry.is_jump || bht_cnt[p_bht_idx][1]);
        p_target = p_taken ? rd_entry.target : pred_pc + XLEN'(4);
    end

    // Prediction register: taken/target hold whenever no prediction is loaded.
    logic            pred_load;
    logic            pred_valid_q, pred_valid_d;
    logic            pred_taken_q, pred_taken_d;
    logic [XLEN-1:0] pred_target_q, pred_target_d;

    assign pred_load = pred_req_valid && !flush;

    always_comb begin
        pred_valid_d  = pred_load;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (pred_load) begin
            pred_taken_d  = p_taken;
            pred_target_d = p_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    // Mispredict: direction disagrees, or taken with a different target.
    logic            mis_q, mis_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [31:0]     bcnt_q, bcnt_d;
    logic [31:0]     mcnt_q, mcnt_d;

    always_comb begin
        mis_d   = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
        redir_d = redir_q;
        if (mis_d) begin
            redir_d = upd_taken ? upd_target : upd_pc + XLEN'(4);
        end
        bcnt_d = bcnt_q;
        if (upd_valid && bcnt_q != BP_EVT_MAX) begin
            bcnt_d = bcnt_q + 32'd1;
        end
        mcnt_d = mcnt_q;
        if (mis_d && mcnt_q != BP_EVT_MAX) begin
            mcnt_d = mcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q   <= 1'b0;
            redir_q <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            mis_q   <= mis_d;
            redir_q <= redir_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_target      = pred_target_q;
    assign mispredict       = mis_q;
    assign redirect_pc      = redir_q;
    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule
